// File: rtl/cest_noise_pwr.sv
// Per-subcarrier noise-power sample generator: |H(s) - H(s-1)|^2 of each subcarrier's LS estimate,
// shifted right by SHIFT and saturated to a non-negative 12-bit signed value.
module cest_noise_pwr #(
    parameter int N     = 64,
    parameter int SHIFT = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic [11:0] din_re,
    input  logic [11:0] din_im,
    input  logic        din_vld,
    output logic [11:0] dout,
    output logic        dout_vld,
    output logic        done,
    output logic [1:0]  o_state
);
    localparam int            CW      = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] SC_LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        EST  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_sc_cnt;
    logic [CW-1:0] w_sc;
    logic [2:0]    r_sym_cnt;
    logic [2:0]    w_sym;
    logic [23:0]   r_buf [N];
    logic [23:0]   w_prev;
    logic          w_accept;
    logic          w_est;
    logic          w_wrap;
    logic          w_last;

    // frame_start restarts the frame in the same cycle, so a coincident sample lands at symbol 0, subcarrier 0.
    assign w_sc    = frame_start ? '0 : r_sc_cnt;
    assign w_sym   = frame_start ? 3'd0 : r_sym_cnt;
    assign w_prev  = r_buf[w_sc];
    assign w_wrap  = (w_sc == SC_LAST);
    assign w_last  = w_est && w_wrap && (w_sym == 3'd4);
    assign o_state = r_state;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_est       = 1'b0;
        if (frame_start) begin
            w_state_nxt = FILL;
            w_accept    = din_vld;
        end else begin
            case (r_state)
                FILL: begin
                    w_accept = din_vld;
                    if (din_vld && w_wrap) w_state_nxt = EST;
                end
                EST: begin
                    w_accept = din_vld;
                    w_est    = din_vld;
                    if (din_vld && w_wrap && (r_sym_cnt == 3'd4)) w_state_nxt = DONE;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_sc_cnt  <= '0;
            r_sym_cnt <= '0;
            for (int i = 0; i < N; i++) r_buf[i] <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_buf[w_sc] <= {din_re, din_im};
                r_sc_cnt    <= w_wrap ? '0 : w_sc + CW'(1);
                if (w_wrap) r_sym_cnt <= (w_sym == 3'd4) ? 3'd0 : w_sym + 3'd1;
                else        r_sym_cnt <= w_sym;
            end else if (frame_start) begin
                r_sc_cnt  <= '0;
                r_sym_cnt <= '0;
            end
        end
    end

    logic signed [12:0] r_s1_dr;
    logic signed [12:0] r_s1_di;
    logic               r_s1_vld;
    logic               r_s1_last;
    logic [11:0]        w_abs_re;
    logic [11:0]        w_abs_im;
    logic [24:0]        w_sq_re;
    logic [24:0]        w_sq_im;
    logic [24:0]        r_s2_pr;
    logic [24:0]        r_s2_pi;
    logic               r_s2_vld;
    logic               r_s2_last;
    logic [25:0]        w_sum;
    logic [25:0]        w_pwr;
    logic [11:0]        w_sat;

    // Squaring the magnitude (at most 4095) keeps the multiplier unsigned.
    assign w_abs_re = r_s1_dr[12] ? 12'(-r_s1_dr) : r_s1_dr[11:0];
    assign w_abs_im = r_s1_di[12] ? 12'(-r_s1_di) : r_s1_di[11:0];
    assign w_sq_re  = 25'(w_abs_re) * 25'(w_abs_re);
    assign w_sq_im  = 25'(w_abs_im) * 25'(w_abs_im);
    assign w_sum    = 26'(r_s2_pr) + 26'(r_s2_pi);
    assign w_pwr    = w_sum >> SHIFT;
    assign w_sat    = (w_pwr > 26'd2047) ? 12'd2047 : w_pwr[11:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_dr   <= '0;
            r_s1_di   <= '0;
            r_s1_vld  <= 1'b0;
            r_s1_last <= 1'b0;
            r_s2_pr   <= '0;
            r_s2_pi   <= '0;
            r_s2_vld  <= 1'b0;
            r_s2_last <= 1'b0;
            dout      <= '0;
            dout_vld  <= 1'b0;
            done      <= 1'b0;
        end else begin
            r_s1_vld  <= w_est;
            r_s1_last <= w_last;
            if (w_est) begin
                r_s1_dr <= $signed({din_re[11], din_re}) - $signed({w_prev[23], w_prev[23:12]});
                r_s1_di <= $signed({din_im[11], din_im}) - $signed({w_prev[11], w_prev[11:0]});
            end
            r_s2_vld  <= r_s1_vld;
            r_s2_last <= r_s1_vld && r_s1_last;
            if (r_s1_vld) begin
                r_s2_pr <= w_sq_re;
                r_s2_pi <= w_sq_im;
            end
            dout_vld <= r_s2_vld;
            done     <= r_s2_vld && r_s2_last;
            if (r_s2_vld) dout <= w_sat;
        end
    end
endmodule
